// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receive word type and length clamp
package uart_pkg;
   localparam int UART_FRAME_W = 10;
   localparam int UART_DATA_W  = 8;
   localparam int UART_MIN_LEN = 5;
   localparam int UART_MAX_LEN = 8;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
   typedef struct packed {
      logic                   err;
      logic [UART_DATA_W-1:0] data;
   } rx_word_t;
   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      return len < 4'(UART_MIN_LEN) ? 4'(UART_MIN_LEN) :
             len > 4'(UART_MAX_LEN) ? 4'(UART_MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: show-ahead synchronous FIFO with registered head and flags
module sync_fifo_fwft #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic             r_empty, r_full;
   logic [WIDTH-1:0] r_dout;
   logic             w_pop, w_push, w_bypass, w_empty_nxt, w_full_nxt;
   logic [PW-1:0]    w_wr_nxt, w_rd_nxt;
   assign w_pop       = rd_en & ~r_empty;
   assign w_push      = wr_en & (~r_full | w_pop);
   assign w_wr_nxt    = r_wr_ptr + PW'(w_push);
   assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);
   assign w_empty_nxt = w_wr_nxt == w_rd_nxt;
   assign w_full_nxt  = w_wr_nxt == {~w_rd_nxt[AW], w_rd_nxt[AW-1:0]};
   // the next head is the slot being written this very edge
   assign w_bypass    = w_push & (r_wr_ptr == w_rd_nxt);
   assign drop        = wr_en & r_full & ~w_pop;
   assign rd_data     = r_dout;
   assign empty       = r_empty;
   assign full        = r_full;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
         r_dout   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_empty  <= w_empty_nxt;
         r_full   <= w_full_nxt;
         if (!w_empty_nxt) r_dout <= w_bypass ? wr_data : r_mem[w_rd_nxt[AW-1:0]];
      end
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART frames, extracts data, checks parity, queues words with statistics
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                    clk_16bd,
   input  logic                    rst,
   input  logic [UART_FRAME_W-1:0] frame,
   input  logic                    frame_valid,
   input  logic [3:0]              frame_length,
   input  logic                    parity,
   input  logic                    parity_type,
   input  logic                    rd_en,
   input  logic                    stat_clr,
   output logic [UART_DATA_W-1:0]  rd_data,
   output logic                    rd_err,
   output logic                    empty,
   output logic                    full,
   output logic                    overflow,
   output logic [CNT_W-1:0]        err_count
);
   logic                    r_vld, r_par, r_ptype, r_overflow;
   logic [UART_FRAME_W-1:0] r_frame;
   logic [3:0]              r_len;
   logic [CNT_W-1:0]        r_err_count;
   logic [UART_DATA_W-1:0]  w_data;
   logic                    w_pbit, w_err, w_drop;
   rx_word_t                w_word, w_dout;
   assign w_data = r_frame[UART_DATA_W-1:0] & (8'hFF >> (4'd8 - r_len));
   assign w_pbit = r_frame[r_len];
   assign w_err  = r_par & ((^w_data ^ w_pbit) != r_ptype);
   assign w_word = '{err: w_err, data: w_data};
   always_ff @(posedge clk_16bd) begin
      if (rst) begin
         r_vld   <= 1'b0;
         r_frame <= '0;
         r_len   <= 4'(UART_MAX_LEN);
         r_par   <= 1'b0;
         r_ptype <= PAR_EVEN;
      end else begin
         r_vld <= frame_valid;
         if (frame_valid) begin
            r_frame <= frame;
            r_len   <= clamp_len(frame_length);
            r_par   <= parity;
            r_ptype <= parity_type;
         end
      end
   end
   sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH($bits(rx_word_t))) u_fifo (
      .clk     (clk_16bd),
      .rst     (rst),
      .wr_en   (r_vld),
      .wr_data (w_word),
      .rd_en   (rd_en),
      .rd_data (w_dout),
      .empty   (empty),
      .full    (full),
      .drop    (w_drop)
   );
   // dropped words still count toward parity statistics
   always_ff @(posedge clk_16bd) begin
      if (rst || stat_clr) begin
         r_overflow  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_drop) r_overflow <= 1'b1;
         if (r_vld && w_err && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
      end
   end
   assign rd_data   = w_dout.data;
   assign rd_err    = w_dout.err;
   assign overflow  = r_overflow;
   assign err_count = r_err_count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus against a queue-based behavioural model plus literal checks
module tb_uart_rx_fifo;
   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   logic             clk_16bd = 1'b0;
   logic             rst = 1'b1;
   logic [9:0]       frame = '0;
   logic             frame_valid = 1'b0;
   logic [3:0]       frame_length = 4'd8;
   logic             parity = 1'b0;
   logic             parity_type = 1'b0;
   logic             rd_en = 1'b0;
   logic             stat_clr = 1'b0;
   logic [7:0]       rd_data;
   logic             rd_err, empty, full, overflow;
   logic [CNT_W-1:0] err_count;
   int cmp = 0;
   int mism = 0;
   int q[$];
   bit pend_v = 0;
   int pend_w = 0;
   bit m_ovf = 0;
   int m_cnt = 0;
   int shown = 0;
   bit armed = 0;

   always #5 clk_16bd = ~clk_16bd;

   uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_16bd     (clk_16bd),
      .rst          (rst),
      .frame        (frame),
      .frame_valid  (frame_valid),
      .frame_length (frame_length),
      .parity       (parity),
      .parity_type  (parity_type),
      .rd_en        (rd_en),
      .stat_clr     (stat_clr),
      .rd_data      (rd_data),
      .rd_err       (rd_err),
      .empty        (empty),
      .full         (full),
      .overflow     (overflow),
      .err_count    (err_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         mism++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int entry(input int f, input int fl, input bit p, input bit pt);
      int l, d, pb;
      bit e;
      l  = fl < 5 ? 5 : (fl > 8 ? 8 : fl);
      d  = f % (1 << l);
      pb = (f >> l) & 1;
      e  = p && ((($countones(d) + pb) % 2) != int'(pt));
      return (int'(e) << 8) | d;
   endfunction

   always @(posedge clk_16bd) begin
      bit pop, was_full;
      if (rst) begin
         q.delete();
         pend_v = 0;
         m_ovf  = 0;
         m_cnt  = 0;
         shown  = 0;
         armed  = 1;
      end else begin
         was_full = q.size() == DEPTH;
         pop = rd_en && q.size() > 0;
         if (pop) void'(q.pop_front());
         if (pend_v) begin
            if (was_full && !pop) m_ovf = 1;
            else q.push_back(pend_w);
            if (pend_w >= 256 && m_cnt < CNT_MAX) m_cnt++;
         end
         if (stat_clr) begin
            m_ovf = 0;
            m_cnt = 0;
         end
         pend_v = frame_valid;
         if (frame_valid) pend_w = entry(int'(frame), int'(frame_length), parity, parity_type);
         if (q.size() > 0) shown = q[0];
      end
   end

   always @(negedge clk_16bd) begin
      if (armed) begin
         chk("empty", 32'(empty), 32'(q.size() == 0));
         chk("full", 32'(full), 32'(q.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("err_count", 32'(err_count), 32'(m_cnt));
         chk("rd_data", 32'(rd_data), 32'(shown % 256));
         chk("rd_err", 32'(rd_err), 32'(shown / 256));
      end
   end

   task automatic tick();
      @(posedge clk_16bd);
      #1;
   endtask

   task automatic send(input logic [9:0] f, input logic [3:0] len, input logic p, input logic pt);
      frame = f;
      frame_length = len;
      parity = p;
      parity_type = pt;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic pop1();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      pop1();
      tick();
      pop1();
      chk("idle_rd_empty", 32'(empty), 32'd1);
      send(10'h0A5, 4'd8, 1'b1, 1'b0);
      tick();
      chk("even_ok_data", 32'(rd_data), 32'hA5);
      chk("even_ok_err", 32'(rd_err), 32'd0);
      pop1();
      send(10'h1A5, 4'd8, 1'b1, 1'b0);
      tick();
      chk("even_bad_data", 32'(rd_data), 32'hA5);
      chk("even_bad_err", 32'(rd_err), 32'd1);
      chk("even_bad_cnt", 32'(err_count), 32'd1);
      pop1();
      send(10'h0C1, 4'd7, 1'b1, 1'b1);
      tick();
      chk("odd7_data", 32'(rd_data), 32'h41);
      chk("odd7_err", 32'(rd_err), 32'd0);
      pop1();
      send(10'h3FF, 4'd3, 1'b0, 1'b0);
      tick();
      chk("clamp5_data", 32'(rd_data), 32'h1F);
      pop1();
      chk("drained", 32'(empty), 32'd1);
      for (int i = 1; i <= 9; i++) send(10'(i), 4'd8, 1'b0, 1'b0);
      chk("full_after8", 32'(full), 32'd1);
      chk("no_ovf_yet", 32'(overflow), 32'd0);
      tick();
      chk("ovf_after9", 32'(overflow), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         chk("order", 32'(rd_data), 32'(i));
         pop1();
      end
      chk("empty_after_reads", 32'(empty), 32'd1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_cnt", 32'(err_count), 32'd0);
      for (int i = 1; i <= 8; i++) send(10'(8'h10 + i), 4'd8, 1'b0, 1'b0);
      tick();
      chk("refull", 32'(full), 32'd1);
      frame = 10'h055;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("swap_full", 32'(full), 32'd1);
      chk("swap_no_ovf", 32'(overflow), 32'd0);
      for (int i = 2; i <= 8; i++) begin
         chk("swap_order", 32'(rd_data), 32'(8'h10 + i));
         pop1();
      end
      chk("swap_last", 32'(rd_data), 32'h55);
      pop1();
      rd_en = 1'b1;
      for (int i = 0; i < 256; i++) send(10'h1A5, 4'd8, 1'b1, 1'b0);
      rd_en = 1'b1;
      tick();
      tick();
      rd_en = 1'b0;
      chk("sat_cnt", 32'(err_count), 32'(CNT_MAX));
      chk("sat_empty", 32'(empty), 32'd1);
      for (int i = 1; i <= 3; i++) send(10'(8'h20 + i), 4'd8, 1'b0, 1'b0);
      tick();
      chk("three_head", 32'(rd_data), 32'h21);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_empty", 32'(empty), 32'd1);
      chk("rst_mid_cnt", 32'(err_count), 32'd0);
      frame = 10'h033;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("inflight_drop", 32'(empty), 32'd1);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the UART receive processor. Captures each completed 10-bit receive frame on `frame_valid` and extracts the data field using the live UART configuration (frame length, parity enable/type).
- Checks parity and pushes {parity_err, data} into a small first-word-fall-through FIFO.
- The consumer (VGA/text side) pops entries at its own pace. Parity-error and overflow statistics are exposed.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of saturating parity-error counter.

Ports:
- clk_16bd  in  1  UART oversampling clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- frame  in  10  received frame bits, data LSB at bit 0, stop bits already stripped.
- frame_valid  in  1  one-cycle strobe; frame is valid this cycle.
- frame_length  in  4  number of data bits (legal 5..8).
- parity  in  1  1 = frame carries a parity bit.
- parity_type  in  1  0 = even, 1 = odd.
- rd_en  in  1  pop request.
- stat_clr  in  1  clears overflow and err_count.
- rd_data  out  8  head entry data, zero-extended above frame_length.
- rd_err  out  1  head entry parity-error flag.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- overflow  out  1  sticky; a word was dropped.
- err_count  out  CNT_W  saturating count of parity-error frames.

Behaviour:
- Reset: all pointers/count to 0; `empty`=1, `full`=0, `overflow`=0, `err_count`=0, `rd_data`=0, `rd_err`=0; capture stage invalid. A reset mid-operation discards all stored and in-flight frames.
- Length clamp: effective length L = 5 if `frame_length`<5, 8 if `frame_length`>8, else `frame_length`.
- Stage 1 (capture): on a `frame_valid` edge, register frame, L, `parity` and `parity_type`. Config is sampled only here; later config changes do not affect captured frames.
- Data extraction: data = frame[L-1:0] zero-extended to 8 bits.
- Parity bit: when `parity`=1, the parity bit is frame[L]. Bits above it are ignored. When `parity`=0, frame[9:L] is ignored.
- Parity error: err = `parity` AND (XOR(data bits, parity bit) != `parity_type`), i.e. even requires the XOR of all to be 0, odd requires it to be 1.
- Stage 2 (push): the edge after capture writes {err, data} into the FIFO. A frame_valid at edge N is visible at the FIFO head (`empty`=0) after edge N+1. Back-to-back frame_valid on consecutive cycles is supported with no loss.
- `err_count`: increments on each frame with err=1 at the push edge, including frames dropped for overflow. Saturates at all-ones.
- FIFO read model: show-ahead. `rd_data`/`rd_err` present the head whenever `empty`=0, and hold their last value when empty.
- Pop: `rd_en`=1 with `empty`=0 pops at the edge. `rd_en` while empty is ignored with no state change.
- Push while full, no pop the same cycle: the word is dropped and `overflow` is set to 1.
- Push and pop in the same cycle: both performed. When full, the head leaves, the new word enters, and `full` stays 1. When count=1, the FIFO stays non-empty with the new head.
- Wrap-around: pointers are log2(DEPTH) bits plus a wrap bit. `full`/`empty` are derived from count or the wrap bit and are registered, so there are no combinational loops from `rd_en`.
- `stat_clr`: at the edge, `overflow`←0 and `err_count`←0. `stat_clr` has priority over a same-cycle overflow or error event, which is then not recorded. FIFO contents are unaffected.

Decomposition:
- Package uart_pkg:
  - constants UART_FRAME_W=10, UART_DATA_W=8, UART_MIN_LEN=5, UART_MAX_LEN=8
  - parity-type localparams PAR_EVEN=0, PAR_ODD=1
  - shared with uart_regfile
- One sub-module: sync_fifo_fwft (generic DEPTH/WIDTH, synchronous reset, show-ahead). It is instantiated here with WIDTH=9. The top level holds the capture stage, extraction/parity logic, and the statistics registers.

Test Plan:
- Reset, then idle → `empty`=1, `full`=0, `overflow`=0, `err_count`=0; `rd_en` pulses cause no change.
- frame_length=8, parity=1, type even, frame=10'h0A5 → after 2 edges, `rd_data`=8'hA5, `rd_err`=0. Repeat with frame=10'h1A5 → `rd_err`=1, `err_count`=1.
- frame_length=7, parity=1, type odd, frame=10'h0C1 → `rd_data`=8'h41, `rd_err`=0. frame_length=3 with parity=0, frame=10'h3FF → `rd_data`=8'h1F (clamped to 5).
- Nine back-to-back frames 8'h01..8'h09 with no reads → `full`=1 after the 8th, `overflow`=1 after the 9th. Reads return 01..08 in order, then `empty`=1. `stat_clr` → `overflow`=0.
- Full FIFO, frame_valid arriving so its push coincides with `rd_en` → no overflow, `full` stays 1, and the new word is read last.
- 256 bad-parity frames with continuous reads → `err_count`=255 (saturated). Assert `rst` with 3 entries queued → `empty`=1 on the next cycle.
